// File: rtl/ysyx_25040111_axi_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read-arbiter state encoding.
package ysyx_25040111_axi_pkg;

    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    // S_IDLE: arbitrate and drain stale beats; S_AR: address phase;
    // S_R: data phase; S_ERR: synthesized SLVERR after a slave timeout.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_ERR  = 2'd3
    } rd_arb_state_e;

endpackage : ysyx_25040111_axi_pkg

// File: rtl/ysyx_25040111_rr_grant2.sv
// Combinational 2-way grant.
//   req[1:0] : request per master (bit 1 = m1)
//   last     : index of the master that owned the previous transaction
//   rr_en    : 1 = round-robin (tie goes to !last), 0 = fixed priority (m1 wins)
//   gnt[1:0] : one-hot grant, zero when nobody requests
module ysyx_25040111_rr_grant2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    // Single requester always wins; only the tie depends on policy.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_en && last) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule : ysyx_25040111_rr_grant2

// File: rtl/ysyx_25040111_rd_arbiter.sv
// 2:1 AXI4-Lite read-channel arbiter: masters m0 (IFU) and m1 (LSU) share one
// read slave. One transaction in flight; the slave address is registered and
// held for the whole transaction; the response goes to the owner only. A
// watchdog answers SLVERR to the owner when the slave never responds.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   mX_araddr/arvalid    : master X read request (held until mX_arready)
//   mX_arready           : request accepted (IDLE only, combinational)
//   mX_rdata/rresp/rvalid: response to master X, mX_rready its handshake
//   s_araddr/s_arvalid   : slave address channel (address registered)
//   s_arready            : slave address accept
//   s_rdata/rresp/rvalid : slave response, s_rready its handshake
module ysyx_25040111_rd_arbiter
    import ysyx_25040111_axi_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RR_EN   = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready
);

    // Keep the timer at least one bit wide even when the watchdog is disabled.
    localparam int unsigned TMR_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    rd_arb_state_e     state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [1:0]        gnt;
    logic              own_rready;
    logic              timeout_hit;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    ysyx_25040111_rr_grant2 u_grant (
        .req   ({m1_arvalid, m0_arvalid}),
        .last  (last_q),
        .rr_en (RR_EN != 0),
        .gnt   (gnt)
    );

    assign own_rready  = owner_q ? m1_rready : m0_rready;
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1));
    assign s_araddr    = araddr_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            araddr_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            araddr_q <= araddr_d;
            timer_q  <= timer_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        araddr_d   = araddr_q;
        timer_d    = timer_q;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        r_valid    = 1'b0;
        r_data     = '0;
        r_resp     = RESP_OKAY;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = RESP_OKAY;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = RESP_OKAY;

        case (state_q)
            S_IDLE: begin
                // Anything the slave returns here is stale and is swallowed.
                s_rready   = 1'b1;
                m0_arready = gnt[0];
                m1_arready = gnt[1];
                if (gnt != 2'b00) begin
                    araddr_d = gnt[1] ? m1_araddr : m0_araddr;
                    owner_d  = gnt[1];
                    timer_d  = '0;
                    state_d  = S_AR;
                end
            end
            S_AR: begin
                s_arvalid = 1'b1;
                timer_d   = timer_q + TMR_W'(1);
                if (timeout_hit) begin
                    state_d = S_ERR;
                end else if (s_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                s_rready = own_rready;
                r_valid  = s_rvalid;
                r_data   = s_rdata;
                r_resp   = s_rresp;
                timer_d  = timer_q + TMR_W'(1);
                // A completing beat wins over a coincident timeout.
                if (s_rvalid && own_rready) begin
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                s_rready = 1'b1;
                r_valid  = 1'b1;
                r_resp   = RESP_SLVERR;
                if (own_rready) begin
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Route the response to the owner only.
        if (owner_q) begin
            m1_rvalid = r_valid;
            m1_rdata  = r_data;
            m1_rresp  = r_resp;
        end else begin
            m0_rvalid = r_valid;
            m0_rdata  = r_data;
            m0_rresp  = r_resp;
        end
    end

endmodule : ysyx_25040111_rd_arbiter

// File: tb/tb_ysyx_25040111_rd_arbiter.sv
// Directed bench for the read arbiter. Instance A is round-robin with an
// 8-cycle watchdog and a controllable CLINT-like slave; instance B is fixed
// priority with an always-ready slave and is only checked for grant order.
module tb_ysyx_25040111_rd_arbiter;

    localparam logic [31:0] MT_LO = 32'h89AB_CDEF;
    localparam logic [31:0] MT_HI = 32'h0000_0012;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;

    logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_rready;

    logic        b_m0_arready, b_m0_rvalid, b_m1_arready, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic [1:0]  b_m0_rresp, b_m1_rresp;
    logic [31:0] b_s_araddr;
    logic        b_s_arvalid, b_s_rready;

    logic        sa_arready = 1'b1;
    logic        sa_mute    = 1'b0;
    logic        sa_inject  = 1'b0;
    logic        sa_rvalid_q = 1'b0;
    logic [31:0] sa_rdata_q  = '0;
    logic        sb_rvalid_q = 1'b0;
    logic [31:0] sb_rdata_q  = '0;

    function automatic logic [31:0] clint_rd(input logic [31:0] a);
        if (a == 32'h0200_0048) return MT_LO;
        if (a == 32'h0200_004C) return MT_HI;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Slave A: accepts an address, returns data the next cycle, holds it until taken.
    always @(posedge clk) begin
        if (sa_rvalid_q && s_rready) sa_rvalid_q <= 1'b0;
        if (s_arvalid && sa_arready && !sa_mute) begin
            sa_rvalid_q <= 1'b1;
            sa_rdata_q  <= clint_rd(s_araddr);
        end
    end

    always @(posedge clk) begin
        if (sb_rvalid_q && b_s_rready) sb_rvalid_q <= 1'b0;
        if (b_s_arvalid) begin
            sb_rvalid_q <= 1'b1;
            sb_rdata_q  <= clint_rd(b_s_araddr);
        end
    end

    ysyx_25040111_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(sa_arready),
        .s_rdata(sa_inject ? 32'hDEAD_BEEF : sa_rdata_q), .s_rresp(2'b00),
        .s_rvalid(sa_rvalid_q | sa_inject), .s_rready(s_rready)
    );

    ysyx_25040111_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(b_m0_arready),
        .m0_rdata(b_m0_rdata), .m0_rresp(b_m0_rresp), .m0_rvalid(b_m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(b_m1_arready),
        .m1_rdata(b_m1_rdata), .m1_rresp(b_m1_rresp), .m1_rvalid(b_m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(1'b1),
        .s_rdata(sb_rdata_q), .s_rresp(2'b00), .s_rvalid(sb_rvalid_q), .s_rready(b_s_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int na;
        int nb;
        int nb0;
        logic [3:0] ga;

        m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        rst_n = 1'b0;
        repeat (3) nxt();

        // Reset values
        smp();
        chk("rst_m0_arready", m0_arready, 1'b0);
        chk("rst_m1_arready", m1_arready, 1'b0);
        chk("rst_m0_rvalid", m0_rvalid, 1'b0);
        chk("rst_m1_rvalid", m1_rvalid, 1'b0);
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_s_rready", s_rready, 1'b1);
        chk("rst_s_araddr", s_araddr, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m0_rresp", m0_rresp, 2'b00);
        nxt(); rst_n = 1'b1;

        // m0 single read of mtime low word
        nxt(); m0_araddr = 32'h0200_0048; m0_arvalid = 1'b1;
        smp();
        chk("t1_m0_arready", m0_arready, 1'b1);
        chk("t1_m1_arready", m1_arready, 1'b0);
        chk("t1_s_arvalid_c0", s_arvalid, 1'b0);
        chk("t1_s_araddr_c0", s_araddr, 32'h0);
        nxt(); m0_arvalid = 1'b0;
        smp();
        chk("t1_s_arvalid_c1", s_arvalid, 1'b1);
        chk("t1_s_araddr_c1", s_araddr, 32'h0200_0048);
        chk("t1_m0_rvalid_c1", m0_rvalid, 1'b0);
        nxt(); smp();
        chk("t1_m0_rvalid_c2", m0_rvalid, 1'b1);
        chk("t1_m0_rdata", m0_rdata, MT_LO);
        chk("t1_m0_rresp", m0_rresp, 2'b00);
        chk("t1_m1_rvalid", m1_rvalid, 1'b0);
        chk("t1_s_araddr_c2", s_araddr, 32'h0200_0048);
        nxt(); smp();
        chk("t1_m0_rvalid_c3", m0_rvalid, 1'b0);
        chk("t1_s_arvalid_c3", s_arvalid, 1'b0);

        // Both masters request continuously: RR alternates, fixed starves m0
        nxt(); rst_n = 1'b0;
        nxt(); rst_n = 1'b1;
        nxt(); m0_araddr = 32'h0200_0048; m1_araddr = 32'h0200_004C;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        na = 0; nb = 0; nb0 = 0; ga = '0;
        for (int c = 0; c < 12; c++) begin
            smp();
            if (m0_arready || m1_arready) begin
                if (na < 4) ga[na] = m1_arready;
                na++;
            end
            if (b_m1_arready) nb++;
            if (b_m0_arready) nb0++;
        end
        nxt(); m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        chk("rr_grant_count", 64'(na), 64'd4);
        chk("rr_grant_order", ga, 4'b1010);
        chk("fix_m1_grants", 64'(nb), 64'd4);
        chk("fix_m0_grants", 64'(nb0), 64'd0);
        repeat (2) nxt();

        // m1 read with rready held low for 5 cycles
        nxt(); m1_araddr = 32'h8000_0010; m1_arvalid = 1'b1; m1_rready = 1'b0;
        smp();
        chk("st_m1_arready", m1_arready, 1'b1);
        nxt(); m1_arvalid = 1'b0;
        nxt();
        for (int c = 0; c < 5; c++) begin
            smp();
            chk("st_m1_rvalid_hold", m1_rvalid, 1'b1);
            chk("st_s_rready_low", s_rready, 1'b0);
            chk("st_m1_rdata_hold", m1_rdata, 32'hDA5A_5A4A);
            chk("st_m0_rvalid", m0_rvalid, 1'b0);
            nxt();
        end
        m1_rready = 1'b1;
        smp();
        chk("st_m1_rvalid_xfer", m1_rvalid, 1'b1);
        chk("st_s_rready_high", s_rready, 1'b1);
        nxt(); smp();
        chk("st_m1_rvalid_after", m1_rvalid, 1'b0);
        nxt(); smp();
        chk("st_m1_rvalid_after2", m1_rvalid, 1'b0);

        // Silent slave: watchdog answers SLVERR, late beat swallowed in IDLE
        nxt(); sa_mute = 1'b1; m0_araddr = 32'h8000_0020; m0_arvalid = 1'b1;
        smp();
        chk("to_m0_arready", m0_arready, 1'b1);
        nxt(); m0_arvalid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            smp();
            chk("to_m0_rvalid_wait", m0_rvalid, 1'b0);
            nxt();
        end
        smp();
        chk("to_m0_rvalid", m0_rvalid, 1'b1);
        chk("to_m0_rresp", m0_rresp, 2'b10);
        chk("to_m0_rdata", m0_rdata, 32'h0);
        chk("to_s_rready", s_rready, 1'b1);
        chk("to_m1_rvalid", m1_rvalid, 1'b0);
        nxt(); sa_inject = 1'b1;
        smp();
        chk("late_m0_rvalid", m0_rvalid, 1'b0);
        chk("late_m1_rvalid", m1_rvalid, 1'b0);
        chk("late_s_rready", s_rready, 1'b1);
        nxt(); sa_inject = 1'b0; sa_mute = 1'b0;
        smp();
        chk("late_m0_rvalid2", m0_rvalid, 1'b0);

        // Reset asserted while in the data phase
        nxt(); m1_araddr = 32'h0200_0048; m1_arvalid = 1'b1; m1_rready = 1'b0;
        nxt(); m1_arvalid = 1'b0;
        nxt(); smp();
        chk("mr_pre_m1_rvalid", m1_rvalid, 1'b1);
        nxt(); rst_n = 1'b0;
        smp();
        chk("mr_m1_rvalid", m1_rvalid, 1'b0);
        chk("mr_s_rready", s_rready, 1'b1);
        chk("mr_s_arvalid", s_arvalid, 1'b0);
        chk("mr_s_araddr", s_araddr, 32'h0);
        chk("mr_m1_rdata", m1_rdata, 32'h0);
        nxt(); rst_n = 1'b1; m1_rready = 1'b1;
        nxt(); m0_araddr = 32'h0200_004C; m0_arvalid = 1'b1;
        smp();
        chk("mr_post_m0_arready", m0_arready, 1'b1);
        nxt(); m0_arvalid = 1'b0;
        nxt(); smp();
        chk("mr_post_m0_rvalid", m0_rvalid, 1'b1);
        chk("mr_post_m0_rdata", m0_rdata, MT_HI);
        chk("mr_post_m1_rvalid", m1_rvalid, 1'b0);
        nxt();

        // Back-to-back m1 reads of mtime low then high word
        m1_araddr = 32'h0200_0048; m1_arvalid = 1'b1;
        smp();
        chk("bb_arready_c0", m1_arready, 1'b1);
        nxt(); m1_araddr = 32'h0200_004C;
        smp();
        chk("bb_arready_c1", m1_arready, 1'b0);
        chk("bb_s_araddr_c1", s_araddr, 32'h0200_0048);
        nxt(); smp();
        chk("bb_rvalid_c2", m1_rvalid, 1'b1);
        chk("bb_rdata_lo", m1_rdata, MT_LO);
        nxt(); smp();
        chk("bb_arready_c3", m1_arready, 1'b1);
        chk("bb_s_araddr_c3", s_araddr, 32'h0200_0048);
        nxt(); m1_arvalid = 1'b0;
        smp();
        chk("bb_s_araddr_c4", s_araddr, 32'h0200_004C);
        chk("bb_s_arvalid_c4", s_arvalid, 1'b1);
        nxt(); smp();
        chk("bb_rvalid_c5", m1_rvalid, 1'b1);
        chk("bb_rdata_hi", m1_rdata, MT_HI);
        nxt(); smp();
        chk("bb_rvalid_c6", m1_rvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ysyx_25040111_rd_arbiter
